data_mem_initiator: RTL and testbench

Wishbone-classic initiator for the STAGE 4 MEMORY data port; the pipeline-side counterpart of the single-port data memory responder. It accepts one load or store request at a time from the pipeline and drives `wb_cyc`/`wb_stb`/`wb_wr_en` with a word-aligned byte-lane mapping. Loads return sign- or zero-extended data. Misaligned accesses, stalls, timeouts and flushes are handled so the pipeline never sees a hung bus.

---
 rtl/data_mem_initiator.sv | 136 +++++++++++++
 tb/tb_data_mem_initiator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_initiator.sv
// data_mem_initiator: Wishbone-classic initiator for the pipeline data port.
// Handles byte-lane mapping, load extension, misalignment, timeout and flush.
module data_mem_initiator #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic                  flush,
    output logic                  done,
    output logic [31:0]           rd_data,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_wr_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [31:0]           wb_wr_data,
    output logic [3:0]            wb_wr_sel,
    input  logic                  wb_ack,
    input  logic                  wb_stall,
    input  logic [31:0]           wb_rd_data
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [2:0]     f3_q;
    logic           accept, err, timeout;
    logic [1:0]     b;
    logic [3:0]     sel;
    logic [31:0]    wdat, sh, ext;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && !flush;
    assign b         = req_addr[1:0];
    assign err       = (req_funct3[1:0] == 2'b01 && b[0]) ||
                       (req_funct3[1:0] == 2'b10 && b != 2'b00) ||
                       (req_funct3[1:0] == 2'b11) ||
                       (req_wr && req_funct3[2]);
    assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        sel  = !req_wr ? 4'b0000 :
               req_funct3[1:0] == 2'b00 ? 4'b0001 << b :
               req_funct3[1:0] == 2'b01 ? (b[1] ? 4'b1100 : 4'b0011) :
               req_funct3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
        wdat = !req_wr ? 32'd0 :
               req_funct3[1:0] == 2'b00 ? {4{req_data[7:0]}} :
               req_funct3[1:0] == 2'b01 ? {2{req_data[15:0]}} : req_data;
        sh   = wb_rd_data >> {wb_addr[1:0], 3'b000};
        ext  = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
               f3_q == 3'b100 ? {24'd0, sh[7:0]} :
               f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
               f3_q == 3'b101 ? {16'd0, sh[15:0]} : sh;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (accept && !err) ? STROBE : IDLE;
            STROBE:  state_nx = (flush || timeout) ? IDLE : (!wb_stall ? WAIT : STROBE);
            WAIT:    state_nx = (flush || wb_ack || timeout) ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_wr_en   <= 1'b0;
            wb_addr    <= '0;
            wb_wr_data <= '0;
            wb_wr_sel  <= '0;
            rd_data    <= '0;
            f3_q       <= '0;
            cnt        <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && err) misaligned <= 1'b1;
                    else if (accept) begin
                        wb_cyc     <= 1'b1;
                        wb_stb     <= 1'b1;
                        wb_wr_en   <= req_wr;
                        wb_addr    <= req_addr;
                        wb_wr_sel  <= sel;
                        wb_wr_data <= wdat;
                        f3_q       <= req_funct3;
                        cnt        <= '0;
                    end
                end
                STROBE: begin
                    cnt <= cnt + 1'b1;
                    if (flush || timeout) begin
                        wb_cyc   <= 1'b0;
                        wb_stb   <= 1'b0;
                        wb_wr_en <= 1'b0;
                        bus_err  <= !flush;
                    end else if (!wb_stall) wb_stb <= 1'b0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // flush beats ack, ack beats timeout
                    if (flush || wb_ack || timeout) begin
                        wb_cyc   <= 1'b0;
                        wb_wr_en <= 1'b0;
                        done     <= !flush && wb_ack;
                        bus_err  <= !flush && !wb_ack;
                    end
                    if (!flush && wb_ack && !wb_wr_en) rd_data <= ext;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_initiator.sv
// tb_data_mem_initiator: directed scoreboard bench with a small Wishbone memory responder.
module tb_data_mem_initiator;
    localparam int AW = 10;
    localparam int TO = 15;

    logic          clk = 0, rst = 1;
    logic          req_valid = 0, req_wr = 0, flush = 0, wb_stall = 0;
    logic [2:0]    req_funct3 = 0;
    logic [AW-1:0] req_addr = 0;
    logic [31:0]   req_data = 0;
    logic          req_ready, done, misaligned, bus_err, wb_cyc, wb_stb, wb_wr_en, wb_ack;
    logic [31:0]   rd_data, wb_wr_data, mem_rd = 0;
    logic [AW-1:0] wb_addr;
    logic [3:0]    wb_wr_sel;
    logic          ack_r = 0, force_ack = 0, slave_en = 1;
    logic [31:0]   mem [256];
    int            errors = 0, checks = 0, c;
    logic [31:0]   mk;

    typedef struct {int kind; logic chk_d; logic [31:0] d;} exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;
    assign wb_ack = ack_r | force_ack;

    data_mem_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_data(req_data), .flush(flush),
        .done(done), .rd_data(rd_data), .misaligned(misaligned), .bus_err(bus_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr),
        .wb_wr_data(wb_wr_data), .wb_wr_sel(wb_wr_sel), .wb_ack(wb_ack),
        .wb_stall(wb_stall), .wb_rd_data(mem_rd)
    );

    initial for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    // Responder: acks one cycle after an unstalled strobe
    always @(posedge clk) begin
        ack_r <= slave_en && wb_cyc && wb_stb && !wb_stall;
        if (slave_en && wb_cyc && wb_stb && !wb_stall) begin
            mem_rd <= mem[wb_addr[9:2]];
            if (wb_wr_en)
                for (int i = 0; i < 4; i++)
                    if (wb_wr_sel[i]) mem[wb_addr[9:2]][8*i +: 8] <= wb_wr_data[8*i +: 8];
        end
    end

    function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && (done || misaligned || bus_err)) begin
            mk = done ? 0 : misaligned ? 1 : 2;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", mk);
            end else begin
                e = q.pop_front();
                chk("sb_kind", mk, e.kind);
                if (e.chk_d && mk == 0) chk("sb_rd_data", rd_data, e.d);
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [AW-1:0] a,
                         input logic [31:0] d, input int kind, input logic [31:0] ed);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin @(negedge clk); n++; end
        if (kind >= 0) q.push_back('{kind, !wr && kind == 0, ed});
        req_valid = 1; req_wr = wr; req_funct3 = f3; req_addr = a; req_data = d;
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_resp(output int cy);
        cy = 1;
        while (!(done || misaligned || bus_err) && cy < 60) begin @(negedge clk); cy++; end
        if (cy >= 60) begin
            checks++;
            errors++;
            $display("FAIL resp_bound: got no response expected one within 60 cycles");
        end
    endtask

    task automatic rw(input logic wr, input logic [2:0] f3, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [31:0] ed);
        issue(wr, f3, a, d, 0, ed);
        wait_resp(c);
        chk("latency", c, 3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ready", req_ready, 1);
        chk("rst_cyc", {wb_cyc, wb_stb, wb_wr_en}, 0);
        chk("rst_pulses", {done, misaligned, bus_err}, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_sel", wb_wr_sel, 0);
        chk("rst_wdata", wb_wr_data, 0);
        chk("rst_rdata", rd_data, 0);

        issue(1, 3'b010, 10'h30, 32'hDEADBEEF, 0, 0);
        chk("sw_bus", {wb_cyc, wb_stb, wb_wr_en}, 3'b111);
        chk("sw_sel", wb_wr_sel, 4'b1111);
        chk("sw_addr", wb_addr, 10'h30);
        chk("sw_wdata", wb_wr_data, 32'hDEADBEEF);
        chk("sw_ready_busy", req_ready, 0);
        wait_resp(c);
        chk("sw_latency", c, 3);
        chk("sw_ready_done", req_ready, 1);
        rw(0, 3'b010, 10'h30, 0, 32'hDEADBEEF);

        issue(1, 3'b000, 10'h32, 32'h000000CD, 0, 0);
        chk("sb_sel", wb_wr_sel, 4'b0100);
        chk("sb_wdata", wb_wr_data, 32'hCDCDCDCD);
        wait_resp(c);
        rw(0, 3'b000, 10'h32, 0, 32'hFFFFFFCD);
        rw(0, 3'b100, 10'h32, 0, 32'h000000CD);

        issue(1, 3'b001, 10'h36, 32'h00001234, 0, 0);
        chk("sh_sel", wb_wr_sel, 4'b1100);
        chk("sh_wdata", wb_wr_data, 32'h12341234);
        wait_resp(c);
        rw(0, 3'b001, 10'h36, 0, 32'h00001234);
        issue(1, 3'b001, 10'h34, 32'h00008001, 0, 0);
        chk("sh_lo_sel", wb_wr_sel, 4'b0011);
        wait_resp(c);
        rw(0, 3'b001, 10'h34, 0, 32'hFFFF8001);
        rw(0, 3'b101, 10'h34, 0, 32'h00008001);
        rw(0, 3'b010, 10'h30, 0, 32'hDECDBEEF);

        issue(0, 3'b010, 10'h31, 0, 1, 0);
        wait_resp(c);
        chk("lw_mis_cycle", c, 1);
        chk("lw_mis_cyc", wb_cyc, 0);
        chk("lw_mis_ready", req_ready, 1);
        issue(0, 3'b001, 10'h33, 0, 1, 0);
        wait_resp(c);
        chk("lh_mis_cycle", c, 1);
        chk("lh_mis_cyc", wb_cyc, 0);
        issue(0, 3'b011, 10'h30, 0, 1, 0);
        wait_resp(c);
        chk("f3_11_cycle", c, 1);
        issue(1, 3'b100, 10'h30, 0, 1, 0);
        wait_resp(c);
        chk("st_f3_2_cycle", c, 1);
        @(negedge clk);
        chk("err_no_cyc", wb_cyc, 0);
        chk("err_ready", req_ready, 1);

        wb_stall = 1;
        issue(0, 3'b010, 10'h34, 0, 0, 32'h12348001);
        for (int i = 1; i <= 3; i++) begin
            chk("stall_stb", {wb_cyc, wb_stb}, 2'b11);
            chk("stall_addr", wb_addr, 10'h34);
            @(negedge clk);
        end
        wb_stall = 0;
        c = 4;
        while (!done && c < 60) begin @(negedge clk); c++; end
        chk("stall_latency", c, 6);

        slave_en = 0;
        issue(0, 3'b010, 10'h30, 0, 2, 0);
        wait_resp(c);
        chk("to_cycle", c, TO + 1);
        chk("to_cyc_low", wb_cyc, 0);
        chk("to_ready", req_ready, 1);
        slave_en = 1;

        issue(0, 3'b010, 10'h30, 0, -1, 0);
        @(negedge clk);
        chk("fl_wait", {wb_cyc, wb_stb, wb_ack}, 3'b101);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("fl_cyc", wb_cyc, 0);
        chk("fl_ready", req_ready, 1);
        force_ack = 1;
        @(negedge clk);
        force_ack = 0;
        repeat (3) @(negedge clk);
        chk("fl_late_ack", {done, wb_cyc}, 0);

        slave_en = 0;
        issue(1, 3'b010, 10'h30, 32'h55555555, -1, 0);
        chk("rs_strobe", wb_cyc, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rs_bus", {wb_cyc, wb_stb, wb_wr_en, wb_wr_sel}, 0);
        chk("rs_addr", wb_addr, 0);
        chk("rs_data", wb_wr_data, 0);
        chk("rs_pulses", {done, misaligned, bus_err}, 0);
        chk("rs_ready", req_ready, 1);
        slave_en = 1;
        rw(0, 3'b010, 10'h30, 0, 32'hDECDBEEF);

        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
